des_iterative_core: RTL and testbench



---
 rtl/des_iterative_core.sv | 223 ++++++++++++++++++++++
 tb/tb_des_iterative_core.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/des_iterative_core.sv
// Iterative DES encrypt/decrypt engine with valid/ready on both sides.
// One bank of ROUNDS_PER_CYCLE Feistel rounds is reused over NUM_STEPS clocks.
module des_iterative_core #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        inValid,
    output logic        inReady,
    input  logic [63:0] plain,
    input  logic [63:0] key,
    input  logic        decrypt,
    output logic        outValid,
    input  logic        outReady,
    output logic [63:0] cipher,
    output logic        busy
);
    localparam int NUM_STEPS = 16 / ROUNDS_PER_CYCLE;

    generate
        if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
              ROUNDS_PER_CYCLE == 4 || ROUNDS_PER_CYCLE == 8 ||
              ROUNDS_PER_CYCLE == 16)) begin : g_bad_rpc
            $fatal(1, "ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    // Tables use FIPS 1-based bit numbers; FIPS bit n sits at vector index W-n.
    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};
    localparam int E_T [48] = '{
        32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13,
        12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21, 22, 23,
        24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
    localparam int P_T [32] = '{
        16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
        2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
        10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
        14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
    localparam int PC2_T [48] = '{
        14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
        23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam int SBOX [8][64] = '{
        '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
          0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
          4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
          15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
        '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
          3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
          0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
          13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
        '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
          13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
          13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
          1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
        '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
          13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
          10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
          3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
        '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
          14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
          4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
          11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
        '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
          10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
          9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
          4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
        '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
          13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
          1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
          6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
        '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
          1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
          7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
          2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};

    function automatic logic [63:0] perm64(input logic [63:0] x, input logic fin);
        perm64 = '0;
        for (int i = 0; i < 64; i++)
            perm64[63-i] = fin ? x[64-FP_T[i]] : x[64-IP_T[i]];
    endfunction

    function automatic logic [55:0] pc1(input logic [63:0] x);
        pc1 = '0;
        for (int i = 0; i < 56; i++) pc1[55-i] = x[64-PC1_T[i]];
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] x);
        pc2 = '0;
        for (int i = 0; i < 48; i++) pc2[47-i] = x[56-PC2_T[i]];
    endfunction

    function automatic logic [47:0] e_exp(input logic [31:0] x);
        e_exp = '0;
        for (int i = 0; i < 48; i++) e_exp[47-i] = x[32-E_T[i]];
    endfunction

    function automatic logic [31:0] p_perm(input logic [31:0] x);
        p_perm = '0;
        for (int i = 0; i < 32; i++) p_perm[31-i] = x[32-P_T[i]];
    endfunction

    function automatic logic [31:0] sboxes(input logic [47:0] x);
        logic [5:0] six;
        sboxes = '0;
        for (int b = 0; b < 8; b++) begin
            six = x[47-6*b -: 6];
            sboxes[31-4*b -: 4] = 4'(SBOX[b][{six[5], six[0], six[4:1]}]);
        end
    endfunction

    // Rounds 1, 2, 9 and 16 (zero-based 0, 1, 8, 15) shift by one, others by two.
    function automatic logic one_shift(input logic [3:0] k);
        return k inside {4'd0, 4'd1, 4'd8, 4'd15};
    endfunction

    function automatic logic [27:0] rol28(input logic [27:0] x, input logic one);
        return one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
    endfunction

    function automatic logic [27:0] ror28(input logic [27:0] x, input logic one);
        return one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
    endfunction

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state, next_state;
    logic [31:0] l, r, lt, rt, fo;
    logic [27:0] c, d, ct, dt;
    logic [47:0] sub;
    logic [3:0]  step, rnd;
    logic        dec, last_step;

    assign last_step = (step == 4'(NUM_STEPS - 1));
    assign inReady   = (state == IDLE);
    assign outValid  = (state == DONE);
    assign busy      = (state != IDLE);

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (inValid) next_state = RUN;
            RUN:     if (last_step) next_state = DONE;
            DONE:    if (outReady) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Decrypt walks the schedule backwards: round k rotates right by S[16-k].
    always_comb begin
        lt  = l;
        rt  = r;
        ct  = c;
        dt  = d;
        rnd = '0;
        sub = '0;
        fo  = '0;
        for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
            rnd = 4'(int'(step) * ROUNDS_PER_CYCLE + j);
            if (!dec) begin
                ct = rol28(ct, one_shift(rnd));
                dt = rol28(dt, one_shift(rnd));
            end else if (rnd != 4'd0) begin
                ct = ror28(ct, one_shift(4'd0 - rnd));
                dt = ror28(dt, one_shift(4'd0 - rnd));
            end
            sub = pc2({ct, dt});
            fo  = p_perm(sboxes(e_exp(rt) ^ sub));
            {lt, rt} = {rt, lt ^ fo};
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            l      <= '0;
            r      <= '0;
            c      <= '0;
            d      <= '0;
            step   <= '0;
            dec    <= 1'b0;
            cipher <= '0;
        end else begin
            unique case (state)
                IDLE: if (inValid) begin
                    {l, r} <= perm64(plain, 1'b0);
                    {c, d} <= pc1(key);
                    dec    <= decrypt;
                    step   <= '0;
                end
                RUN: begin
                    l    <= lt;
                    r    <= rt;
                    c    <= ct;
                    d    <= dt;
                    step <= step + 4'd1;
                    if (last_step) cipher <= perm64({rt, lt}, 1'b1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_des_iterative_core.sv
// Directed bench for des_iterative_core: known-answer vectors, latency,
// backpressure, mid-run reset, throughput and random round trips.
module tb_des_iterative_core;
    parameter int RPC = 1;
    localparam int NS = 16 / RPC;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        inValid = 1'b0;
    logic        inReady;
    logic [63:0] plain = '0;
    logic [63:0] key = '0;
    logic        decrypt = 1'b0;
    logic        outValid;
    logic        outReady = 1'b0;
    logic [63:0] cipher;
    logic        busy;

    int checks = 0;
    int errors = 0;

    des_iterative_core #(.ROUNDS_PER_CYCLE(RPC)) dut (
        .clk(clk), .resetN(resetN), .inValid(inValid), .inReady(inReady),
        .plain(plain), .key(key), .decrypt(decrypt), .outValid(outValid),
        .outReady(outReady), .cipher(cipher), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [63:0] key;
        logic [63:0] plain;
        logic        dec;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where outValid is first seen.
    task automatic do_block(input logic [63:0] k, input logic [63:0] p,
                            input logic dm, input bit hold,
                            output logic [63:0] res, output int lat);
        int n = 0;
        while (!inReady && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!inReady) chk("inready_timeout", {63'd0, inReady}, 64'd1);
        key = k;
        plain = p;
        decrypt = dm;
        inValid = 1'b1;
        @(posedge clk);
        lat = 0;
        @(negedge clk);
        inValid = 1'b0;
        key = ~k;
        plain = ~p;
        decrypt = ~dm;
        while (!outValid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        res = cipher;
        if (!hold) begin
            outReady = 1'b1;
            @(negedge clk);
            outReady = 1'b0;
        end
    endtask

    initial begin
        logic [63:0] res, res2, held, kr, pr;
        int lat;
        int stamps [3];
        int ns_seen, cyc;
        bit stable;

        vecs[0] = '{"enc_fips", 64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0, 64'h85E813540F0AB405};
        vecs[1] = '{"dec_fips", 64'h133457799BBCDFF1, 64'h85E813540F0AB405, 1'b1, 64'h0123456789ABCDEF};
        vecs[2] = '{"enc_8787", 64'h0E329232EA6D0D73, 64'h8787878787878787, 1'b0, 64'h0000000000000000};
        vecs[3] = '{"dec_8787", 64'h0E329232EA6D0D73, 64'h0000000000000000, 1'b1, 64'h8787878787878787};
        vecs[4] = '{"enc_zero", 64'h0000000000000000, 64'h0000000000000000, 1'b0, 64'h8CA64DE9C1B123A7};
        vecs[5] = '{"enc_parity", 64'h0101010101010101, 64'h0000000000000000, 1'b0, 64'h8CA64DE9C1B123A7};
        vecs[6] = '{"dec_weak", 64'h0101010101010101, 64'h8CA64DE9C1B123A7, 1'b1, 64'h0000000000000000};
        vecs[7] = '{"enc_ones", 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0, 64'h7359B2163E4EDC58};
        vecs[8] = '{"enc_now", 64'h0123456789ABCDEF, 64'h4E6F772069732074, 1'b0, 64'h3FA40E8A984D4815};
        vecs[9] = '{"dec_now", 64'h0123456789ABCDEF, 64'h3FA40E8A984D4815, 1'b1, 64'h4E6F772069732074};

        #12;
        chk("rst_inready", {63'd0, inReady}, 64'd1);
        chk("rst_outvalid", {63'd0, outValid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_cipher", cipher, 64'd0);
        @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            do_block(vecs[i].key, vecs[i].plain, vecs[i].dec, 1'b0, res, lat);
            chk(vecs[i].name, res, vecs[i].exp);
            chk({vecs[i].name, "_lat"}, 64'(lat), 64'(NS));
        end

        // Backpressure with an ignored second block.
        do_block(vecs[0].key, vecs[0].plain, 1'b0, 1'b1, held, lat);
        chk("bp_result", held, vecs[0].exp);
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                key = vecs[2].key;
                plain = vecs[2].plain;
                inValid = 1'b1;
            end
            if (i == 6) inValid = 1'b0;
            @(negedge clk);
            if (cipher !== held || inReady !== 1'b0 || outValid !== 1'b1) stable = 1'b0;
        end
        chk("bp_stable", {63'd0, stable}, 64'd1);
        outReady = 1'b1;
        @(negedge clk);
        outReady = 1'b0;
        chk("bp_release_outvalid", {63'd0, outValid}, 64'd0);
        chk("bp_release_inready", {63'd0, inReady}, 64'd1);
        repeat (3) @(negedge clk);
        chk("bp_not_queued", {63'd0, busy}, 64'd0);

        // Reset in the middle of a run.
        key = vecs[0].key;
        plain = vecs[0].plain;
        decrypt = 1'b0;
        inValid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        inValid = 1'b0;
        repeat (NS > 8 ? 7 : NS - 1) @(negedge clk);
        #2 resetN = 1'b0;
        #1;
        chk("midrst_inready", {63'd0, inReady}, 64'd1);
        chk("midrst_outvalid", {63'd0, outValid}, 64'd0);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_cipher", cipher, 64'd0);
        @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);
        do_block(vecs[0].key, vecs[0].plain, 1'b0, 1'b0, res, lat);
        chk("after_rst_enc", res, vecs[0].exp);
        chk("after_rst_lat", 64'(lat), 64'(NS));

        // Back-to-back throughput with outReady held high.
        key = vecs[8].key;
        plain = vecs[8].plain;
        decrypt = 1'b0;
        outReady = 1'b1;
        inValid = 1'b1;
        ns_seen = 0;
        cyc = 0;
        while (ns_seen < 3 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (outValid) begin
                stamps[ns_seen] = cyc;
                chk("tput_result", cipher, vecs[8].exp);
                ns_seen++;
            end
        end
        inValid = 1'b0;
        chk("tput_count", 64'(ns_seen), 64'd3);
        chk("tput_gap1", 64'(stamps[1] - stamps[0]), 64'(NS + 2));
        chk("tput_gap2", 64'(stamps[2] - stamps[1]), 64'(NS + 2));
        repeat (NS + 3) @(negedge clk);
        outReady = 1'b0;
        chk("tput_idle", {63'd0, busy}, 64'd0);

        // Random encrypt/decrypt round trips.
        for (int i = 0; i < 20; i++) begin
            kr = {$urandom, $urandom};
            pr = {$urandom, $urandom};
            do_block(kr, pr, 1'b0, 1'b0, res, lat);
            do_block(kr, res, 1'b1, 1'b0, res2, lat);
            chk("roundtrip", res2, pr);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
